// File: rtl/debug_probe_mux.sv
// Debug probe multiplexer between the cpu core and the FPGA header pins.
// A debounced button or an auto-scan prescaler selects the channel, a debounced freeze toggle holds the output.

module debug_probe_button #(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic clock_input,
  input  logic reset,
  input  logic raw,
  output logic press
);

  logic                     meta;
  logic                     level;
  logic                     stable;
  logic [DEBOUNCE_BITS-1:0] count;
  logic                     settled;

  assign settled = (count == '1);

  // NOTE: non-blocking assignments make every register sample pre-edge values, so the two-flop chain really is two flops.
  always_ff @(posedge clock_input or negedge reset) begin
    if (!reset) begin
      meta  <= 1'b0;
      level <= 1'b0;
    end else begin
      meta  <= raw;
      level <= meta;
    end
  end

  // The level must disagree with the debounced state for a full window before it is accepted.
  always_ff @(posedge clock_input or negedge reset) begin
    if (!reset) begin
      stable <= 1'b0;
      count  <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (level == stable) begin
        count <= '0;
      end else if (settled) begin
        stable <= level;
        count  <= '0;
        press  <= level;
      end else begin
        count <= count + DEBOUNCE_BITS'(1);
      end
    end
  end

endmodule

module debug_probe_mux #(
  parameter  int WIDTH         = 16,
  parameter  int CHANNELS      = 4,
  parameter  int PRESCALE_BITS = 24,
  parameter  int DEBOUNCE_BITS = 16,
  localparam int CH_W          = $clog2(CHANNELS)
) (
  input  logic                      clock_input,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] probe_bus,
  input  logic                      next_button,
  input  logic                      freeze_button,
  input  logic                      auto_mode,
  output logic [WIDTH-1:0]          probe_out,
  output logic [CH_W-1:0]           channel_out,
  output logic                      frozen,
  output logic                      heartbeat
);

  logic                     next_press;
  logic                     freeze_press;
  logic [PRESCALE_BITS-1:0] prescale;
  logic                     tick;
  logic                     advance;
  logic [CH_W-1:0]          channel_next;
  logic [WIDTH-1:0]         selected;

  debug_probe_button #(
    .DEBOUNCE_BITS (DEBOUNCE_BITS)
  ) u_next_button (
    .clock_input (clock_input),
    .reset       (reset),
    .raw         (next_button),
    .press       (next_press)
  );

  debug_probe_button #(
    .DEBOUNCE_BITS (DEBOUNCE_BITS)
  ) u_freeze_button (
    .clock_input (clock_input),
    .reset       (reset),
    .raw         (freeze_button),
    .press       (freeze_press)
  );

  always_ff @(posedge clock_input or negedge reset) begin
    if (!reset) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + PRESCALE_BITS'(1);
    end
  end

  assign tick      = &prescale;
  assign heartbeat = prescale[PRESCALE_BITS-1];

  // A press and a tick in the same cycle merge into one advance.
  assign advance = (next_press | (auto_mode & tick)) & ~frozen;

  // NOTE: the default is assigned first so every path drives the value and no latch is inferred.
  always_comb begin
    channel_next = channel_out;
    if (advance) begin
      channel_next = (channel_out == CH_W'(CHANNELS - 1)) ? '0 : channel_out + CH_W'(1);
    end
  end

  // Explicit compare per channel keeps a non-power-of-two channel count from indexing past the bus.
  always_comb begin
    selected = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (channel_out == CH_W'(c)) begin
        selected = probe_bus[c*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock_input or negedge reset) begin
    if (!reset) begin
      channel_out <= '0;
      frozen      <= 1'b0;
      probe_out   <= '0;
    end else begin
      channel_out <= channel_next;
      if (freeze_press) begin
        frozen <= ~frozen;
      end
      if (!frozen) begin
        probe_out <= selected;
      end
    end
  end

endmodule

// File: tb/tb_debug_probe_mux.sv
// Self-checking bench for debug_probe_mux: directed scenarios plus randomized traffic,
// all compared against a per-edge behavioural model of the probe multiplexer.

module tb_debug_probe_mux;

  localparam int WIDTH         = 16;
  localparam int CHANNELS      = 3;
  localparam int PRESCALE_BITS = 4;
  localparam int DEBOUNCE_BITS = 2;
  localparam int CH_W          = $clog2(CHANNELS);
  localparam int PERIOD        = 1 << PRESCALE_BITS;
  localparam int DB_WINDOW     = 1 << DEBOUNCE_BITS;
  localparam int VW            = WIDTH + CH_W + 2;

  logic                      clk           = 1'b0;
  logic                      rst_n         = 1'b0;
  logic [CHANNELS*WIDTH-1:0] probe_bus     = '0;
  logic                      next_button   = 1'b0;
  logic                      freeze_button = 1'b0;
  logic                      auto_mode     = 1'b0;
  logic [WIDTH-1:0]          probe_out;
  logic [CH_W-1:0]           channel_out;
  logic                      frozen;
  logic                      heartbeat;
  logic [VW-1:0]             dut_vec;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] base [CHANNELS] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};

  debug_probe_mux #(
    .WIDTH         (WIDTH),
    .CHANNELS      (CHANNELS),
    .PRESCALE_BITS (PRESCALE_BITS),
    .DEBOUNCE_BITS (DEBOUNCE_BITS)
  ) dut (
    .clock_input   (clk),
    .reset         (rst_n),
    .probe_bus     (probe_bus),
    .next_button   (next_button),
    .freeze_button (freeze_button),
    .auto_mode     (auto_mode),
    .probe_out     (probe_out),
    .channel_out   (channel_out),
    .frozen        (frozen),
    .heartbeat     (heartbeat)
  );

  always #5 clk = ~clk;

  assign dut_vec = {probe_out, channel_out, frozen, heartbeat};

  // Reference model state: edge count since reset, last two raw samples per button,
  // run length of disagreeing samples, accepted level and pending press per button.
  typedef struct packed {
    int unsigned       n;
    int unsigned       ch;
    logic              frozen;
    logic [WIDTH-1:0]  probe;
    logic [1:0][1:0]   hist;
    logic [1:0]        stable;
    logic [1:0][7:0]   run;
    logic [1:0]        press;
  } model_t;

  model_t mdl;

  function automatic model_t model_next(input model_t m, input logic [1:0] raw,
                                        input logic am, input logic [CHANNELS*WIDTH-1:0] bus);
    model_t r;
    logic   s;
    r       = m;
    r.n     = m.n + 1;
    r.press = '0;
    for (int b = 0; b < 2; b++) begin
      s         = m.hist[b][1];
      r.hist[b] = {m.hist[b][0], raw[b]};
      if (s == m.stable[b]) begin
        r.run[b] = '0;
      end else if (int'(m.run[b]) + 1 == DB_WINDOW) begin
        r.stable[b] = s;
        r.run[b]    = '0;
        r.press[b]  = s;
      end else begin
        r.run[b] = m.run[b] + 8'd1;
      end
    end
    if ((m.press[0] || (am && (r.n % PERIOD) == 0)) && !m.frozen) r.ch = (m.ch + 1) % CHANNELS;
    if (m.press[1]) r.frozen = !m.frozen;
    if (!m.frozen) r.probe = bus[m.ch*WIDTH +: WIDTH];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl <= '0;
    else        mdl <= model_next(mdl, {freeze_button, next_button}, auto_mode, probe_bus);
  end

  function automatic logic [VW-1:0] model_vec();
    return {mdl.probe, CH_W'(mdl.ch), mdl.frozen, (mdl.n % PERIOD) >= (PERIOD / 2)};
  endfunction

  task automatic do_reset(input logic am);
    @(negedge clk);
    rst_n         = 1'b0;
    next_button   = 1'b0;
    freeze_button = 1'b0;
    auto_mode     = am;
    probe_bus     = {base[2], base[1], base[0]};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    repeat (2) @(negedge clk);
    vectors++;
    if (channel_out !== CH_W'(0)) begin
      $display("FAIL reset_channel: got %0d expected 0", channel_out); miscompares++;
    end
    vectors++;
    if (probe_out !== base[0]) begin
      $display("FAIL reset_probe: got %h expected %h", probe_out, base[0]); miscompares++;
    end
    vectors++;
    if (frozen !== 1'b0) begin
      $display("FAIL reset_frozen: got %b expected 0", frozen); miscompares++;
    end
    vectors++;
    if (dut_vec !== model_vec()) begin
      $display("FAIL reset_model: got %h expected %h", dut_vec, model_vec()); miscompares++;
    end
  endtask

  task automatic test_next_press();
    int               exp_ch;
    logic [WIDTH-1:0] exp_probe;
    for (int p = 0; p < 3; p++) begin
      next_button = 1'b1;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        exp_ch    = (j >= 6) ? (p + 1) % CHANNELS : p;
        exp_probe = base[(j >= 7) ? (p + 1) % CHANNELS : p];
        vectors++;
        if (channel_out !== CH_W'(exp_ch) || probe_out !== exp_probe) begin
          $display("FAIL next_press%0d_edge%0d: got ch=%0d probe=%h expected ch=%0d probe=%h",
                   p, j, channel_out, probe_out, exp_ch, exp_probe);
          miscompares++;
        end
        vectors++;
        if (dut_vec !== model_vec()) begin
          $display("FAIL next_press_model: got %h expected %h", dut_vec, model_vec()); miscompares++;
        end
        if (j == 9) next_button = 1'b0;
      end
    end
  endtask

  task automatic test_bounce();
    for (int j = 0; j < 40; j++) begin
      next_button = (j < 3) || (j >= 4 && j < 7) || (j >= 15 && j < 25);
      @(negedge clk);
      vectors++;
      if (dut_vec !== model_vec()) begin
        $display("FAIL bounce_model: got %h expected %h", dut_vec, model_vec()); miscompares++;
      end
      if (j == 14) begin
        vectors++;
        if (channel_out !== CH_W'(0)) begin
          $display("FAIL bounce_no_advance: got %0d expected 0", channel_out); miscompares++;
        end
      end
    end
    vectors++;
    if (channel_out !== CH_W'(1) || probe_out !== base[1]) begin
      $display("FAIL bounce_single_advance: got ch=%0d probe=%h expected ch=1 probe=%h",
               channel_out, probe_out, base[1]);
      miscompares++;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (dut_vec !== '0) begin
      $display("FAIL async_reset_outputs: got %h expected 0", dut_vec); miscompares++;
    end
    vectors++;
    if (dut_vec !== model_vec()) begin
      $display("FAIL async_reset_model: got %h expected %h", dut_vec, model_vec()); miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_auto_scan();
    do_reset(1'b1);
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      vectors++;
      if (channel_out !== CH_W'((n / PERIOD) % CHANNELS) || heartbeat !== ((n % PERIOD) >= PERIOD / 2)) begin
        $display("FAIL auto_scan_edge%0d: got ch=%0d hb=%b expected ch=%0d hb=%b", n, channel_out,
                 heartbeat, (n / PERIOD) % CHANNELS, (n % PERIOD) >= PERIOD / 2);
        miscompares++;
      end
      vectors++;
      if (dut_vec !== model_vec()) begin
        $display("FAIL auto_scan_model: got %h expected %h", dut_vec, model_vec()); miscompares++;
      end
    end
    auto_mode = 1'b0;
  endtask

  task automatic test_freeze();
    do_reset(1'b0);
    for (int j = 0; j < 120; j++) begin
      next_button   = (j < 10) || (j >= 45 && j < 55);
      freeze_button = (j >= 20 && j < 30) || (j >= 100 && j < 110);
      auto_mode     = (j >= 45 && j < 100);
      if (j == 40) probe_bus[WIDTH +: WIDTH] = 16'h1234;
      @(negedge clk);
      vectors++;
      if (dut_vec !== model_vec()) begin
        $display("FAIL freeze_model: got %h expected %h", dut_vec, model_vec()); miscompares++;
      end
      if (j == 39 || j == 44 || j == 99 || j == 105) begin
        vectors++;
        if (frozen !== 1'b1 || probe_out !== 16'hBBBB || channel_out !== CH_W'(1)) begin
          $display("FAIL freeze_hold_edge%0d: got fr=%b probe=%h ch=%0d expected fr=1 probe=bbbb ch=1",
                   j, frozen, probe_out, channel_out);
          miscompares++;
        end
      end
      if (j == 106) begin
        vectors++;
        if (frozen !== 1'b0 || probe_out !== 16'hBBBB) begin
          $display("FAIL unfreeze_edge: got fr=%b probe=%h expected fr=0 probe=bbbb", frozen, probe_out);
          miscompares++;
        end
      end
      if (j == 107) begin
        vectors++;
        if (probe_out !== 16'h1234) begin
          $display("FAIL unfreeze_resume: got %h expected 1234", probe_out); miscompares++;
        end
      end
    end
  endtask

  task automatic test_press_on_tick();
    do_reset(1'b1);
    for (int j = 0; j < 40; j++) begin
      next_button = (j >= 9 && j < 19);
      @(negedge clk);
      vectors++;
      if (dut_vec !== model_vec()) begin
        $display("FAIL press_on_tick_model: got %h expected %h", dut_vec, model_vec()); miscompares++;
      end
      if (j == 14 || j == 15 || j == 30 || j == 31) begin
        vectors++;
        if (channel_out !== CH_W'((j + 1) / PERIOD)) begin
          $display("FAIL press_on_tick_edge%0d: got %0d expected %0d", j + 1, channel_out, (j + 1) / PERIOD);
          miscompares++;
        end
      end
    end
    auto_mode = 1'b0;
  endtask

  task automatic test_random();
    int hold_next = 0;
    int hold_frz  = 0;
    int hold_auto = 0;
    for (int j = 0; j < 800; j++) begin
      if (hold_next == 0) begin
        next_button = 1'($urandom_range(0, 1));
        hold_next   = $urandom_range(1, 9);
      end
      if (hold_frz == 0) begin
        freeze_button = 1'($urandom_range(0, 1));
        hold_frz      = $urandom_range(1, 12);
      end
      if (hold_auto == 0) begin
        auto_mode = 1'($urandom_range(0, 1));
        hold_auto = $urandom_range(1, 60);
      end
      hold_next--;
      hold_frz--;
      hold_auto--;
      for (int c = 0; c < CHANNELS; c++) probe_bus[c*WIDTH +: WIDTH] = WIDTH'($urandom());
      @(negedge clk);
      vectors++;
      if (dut_vec !== model_vec()) begin
        $display("FAIL random_cycle%0d: got %h expected %h", j, dut_vec, model_vec()); miscompares++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_next_press();
    test_bounce();
    test_async_reset();
    test_auto_scan();
    test_freeze();
    test_press_on_tick();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debug_probe_mux.md
# debug_probe_mux

Board-level debug probe multiplexer between the `cpu` core and the FPGA header pins. It generalises the fixed wiring of register/PC peeks to output pins into CHANNELS selectable WIDTH-bit probe channels. A debounced push-button steps the channel, an optional auto-scan mode steps it from an internal prescaler, and a debounced freeze button holds the displayed value. It also drives a slow heartbeat for an LED.

## Interface
- WIDTH, 16, bits per probe channel and width of `probe_out`
- CHANNELS, 4, number of probe channels; must be ≥2, need not be a power of two
- PRESCALE_BITS, 24, auto-scan/heartbeat prescaler width
- DEBOUNCE_BITS, 16, debounce window is 2^DEBOUNCE_BITS cycles
- CH_W (local), $clog2(CHANNELS)

Ports:
- `clock_input`  in  1  sole clock
- `reset`  in  1  asynchronous, active-low reset
- `probe_bus`  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]; synchronous to `clock_input`
- `next_button`  in  1  raw asynchronous button, active-high; steps channel
- `freeze_button`  in  1  raw asynchronous button, active-high; toggles freeze
- `auto_mode`  in  1  synchronous level; 1 = auto-scan channels on prescaler tick
- `probe_out`  out  WIDTH  registered value of selected channel
- `channel_out`  out  CH_W  current channel index
- `frozen`  out  1  1 = `probe_out` held
- `heartbeat`  out  1  prescaler MSB

## Operation
- Reset (asserted low, asynchronous) clears all state immediately: `probe_out`=0, `channel_out`=0, `frozen`=0, `heartbeat`=0, synchronisers, debounced states, debounce counters and prescaler all 0. An in-progress debounce is discarded.
- Each button path:
  - 2-FF synchroniser, giving the synchronised level `s`.
  - Debounce counter: while `s` ≠ debounced state `d`, the counter increments each cycle. Any cycle with `s` == `d` clears it.
  - When the counter equals 2^DEBOUNCE_BITS−1 and `s` ≠ `d`, then at the next edge `d` ← `s` and the counter clears.
  - A 0→1 change of `d` produces a registered one-cycle press pulse. Release produces no pulse.
- Prescaler: free-running PRESCALE_BITS up-counter that wraps. `tick` = counter all-ones. `heartbeat` = counter MSB.
- Channel advance event = next-press pulse OR (`auto_mode` AND `tick`). The event is ignored while `frozen`=1.
  - On an event, `channel_out` ← `channel_out`+1, wrapping from CHANNELS−1 to 0.
  - A press pulse and a tick in the same cycle advance the channel once, not twice.
- Freeze press pulse toggles `frozen`.
- `probe_out`: each edge, if `frozen` (pre-edge value) is 0, it loads `probe_bus` slice selected by the pre-edge `channel_out`; otherwise it holds.
  - The value shown after freezing is the sample taken at the toggle edge.
- Unfreezing resumes loading at the following edge.
- No arithmetic beyond the counters. All counters wrap silently.

## Timing
- Data latency: `probe_out` reflects `probe_bus` one edge after sampling. After a channel change, `probe_out` shows the new channel one edge after `channel_out` changes.
- Button latency: the raw input is first sampled high at edge k.
  - `s`=1 after k+1.
  - The debounce counter reaches 2^DEBOUNCE_BITS−1 after k+2^DEBOUNCE_BITS.
  - `d` flips and the pulse registers at edge k+2^DEBOUNCE_BITS+1.
  - `channel_out`/`frozen` updates at edge k+2^DEBOUNCE_BITS+2.
- Auto-scan: `channel_out` updates at the same edge at which the prescaler wraps all-ones→0, i.e. every 2^PRESCALE_BITS cycles with the first advance at edge 2^PRESCALE_BITS after reset release. `auto_mode` is sampled in the tick cycle.
- A bounce shorter than 2^DEBOUNCE_BITS cycles produces no pulse and restarts the window.
- A held button produces exactly one pulse per press.

## Test plan
Parameters for all scenarios: WIDTH=16, CHANNELS=3, DEBOUNCE_BITS=2, PRESCALE_BITS=4. `probe_bus` = {16'hCCCC,16'hBBBB,16'hAAAA}.
- Reset then idle 2 cycles -> `channel_out`=0, `probe_out`=16'hAAAA, `frozen`=0. Assert `reset` low mid-run -> all outputs 0 immediately without a clock.
- Press `next_button` three times, each held 10 cycles and released 10 cycles -> channel 1,2,0. Each change lands 6 edges after first high sample. `probe_out` follows: BBBB, CCCC, AAAA.
- `next_button` pulses high for 3 cycles, low 1, high 3 -> no channel change. Then held 10 cycles -> exactly one advance.
- `auto_mode`=1 -> channel advances every 16 cycles, first at edge 16 after reset release, sequence 1,2,0,1. `heartbeat` toggles every 8 cycles.
- Press `freeze_button` on channel 1 -> `frozen`=1, `probe_out` holds BBBB. Change channel 1 to 16'h1234 -> `probe_out` stays BBBB. Press `next_button` and let auto ticks elapse -> channel unchanged. Press freeze again -> `probe_out`=1234 one edge after `frozen` drops.
- Time a `next_button` pulse to coincide with an auto tick -> channel advances by exactly 1.
